// File: rtl/vga_fb_slave.sv
// vga_fb_slave: VGA-side bus slave with a single-port framebuffer RAM.
// CPU requests arrive as write/read pins and are answered with a four-phase
// ACK. A scan-out engine shares the RAM port and has priority on fetch slots.
// It generates hsync/vsync and a pixel word stream aligned to those syncs.

module vga_fb_slave #(
    parameter int word_width   = 32,
    parameter int fb_aw        = 12,
    parameter int PIX_SHIFT    = 3,
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [word_width-1:0] vga_ctrl,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] wr_data,
    output logic [word_width-1:0] vga_stat,
    output logic [word_width-1:0] rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic [word_width-1:0] pixel,
    output logic                  pixel_valid
);

    localparam int FB_WORDS = 2 ** fb_aw;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK_HI = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  op_wr_q, op_wr_d;
    logic [word_width-1:0] addr_q, addr_d;
    logic [word_width-1:0] wdata_q, wdata_d;
    logic [word_width-1:0] rd_data_q, rd_data_d;

    logic [HW-1:0]         hcnt_q, hcnt_d;
    logic [VW-1:0]         vcnt_q, vcnt_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  act_q, act_d;

    logic [word_width-1:0] mem [FB_WORDS];
    logic [word_width-1:0] pix_ram_q;
    logic [word_width-1:0] cpu_ram_q;

    logic                  request;
    logic                  active;
    logic                  fetch_slot;
    logic                  access_go;
    logic                  in_range;
    logic                  ram_we;
    logic                  cpu_rd_en;
    logic [31:0]           fetch_full;
    logic [fb_aw-1:0]      fetch_addr;
    logic [fb_aw-1:0]      ram_addr;
    logic                  unused_bits;

    // Shared RAM port arbitration: scan-out fetch slots win, CPU waits a cycle.
    always_comb begin
        request    = vga_ctrl[0] | vga_ctrl[1];
        active     = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
        fetch_slot = active && (hcnt_q[PIX_SHIFT-1:0] == '0);
        fetch_full = 32'(vcnt_q >> PIX_SHIFT) * 32'(H_ACTIVE >> PIX_SHIFT)
                   + 32'(hcnt_q >> PIX_SHIFT);
        fetch_addr = fetch_full[fb_aw-1:0];
        in_range   = (addr_q[word_width-1:fb_aw] == '0);
        access_go  = (state_q == ACCESS) && !fetch_slot;
        ram_addr   = fetch_slot ? fetch_addr : addr_q[fb_aw-1:0];
        ram_we     = access_go && op_wr_q && in_range;
        cpu_rd_en  = access_go && !op_wr_q;
        unused_bits = ^{vga_ctrl[word_width-1:2], fetch_full[31:fb_aw]};
    end

    // Single-port synchronous RAM; the read lands in the requester's register.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= wdata_q;
        end
        if (fetch_slot) begin
            pix_ram_q <= mem[ram_addr];
        end
        if (cpu_rd_en) begin
            cpu_ram_q <= mem[ram_addr];
        end
    end

    // Raster counters and the one-cycle-delayed sync/active flags.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hcnt_q == HW'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == VW'(V_TOTAL - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end
        hsync_d = !((hcnt_q >= HW'(H_SYNC_START)) && (hcnt_q < HW'(H_SYNC_END)));
        vsync_d = !((vcnt_q >= VW'(V_SYNC_START)) && (vcnt_q < VW'(V_SYNC_END)));
        act_d   = active;
    end

    // Handshake FSM: latch request, wait for a free port, then hold ACK.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (request && !ack_q) begin
                    addr_d  = addr;
                    wdata_d = wr_data;
                    op_wr_d = vga_ctrl[0];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!fetch_slot) begin
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!ack_q && !op_wr_q) begin
                    rd_data_d = in_range ? cpu_ram_q : '0;
                end
                if (request) begin
                    ack_d = 1'b1;
                end else begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            act_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            act_q     <= act_d;
        end
    end

    assign vga_stat    = {{(word_width-1){1'b0}}, ack_q};
    assign rd_data     = rd_data_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_valid = act_q;
    assign pixel       = act_q ? pix_ram_q : '0;

endmodule

// File: tb/tb_vga_fb_slave.sv
// tb_vga_fb_slave: directed bench for vga_fb_slave using a small raster
// geometry. CPU accesses go through a scoreboard queue; the video outputs are
// compared every cycle against a counter and memory model during frame checks.

module tb_vga_fb_slave;

    localparam int HA  = 8;
    localparam int HT  = 12;
    localparam int HSS = 9;
    localparam int HSE = 11;
    localparam int VA  = 4;
    localparam int VT  = 6;
    localparam int VSS = 4;
    localparam int VSE = 5;
    localparam int S   = 1;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic [31:0] vga_ctrl = '0;
    logic [31:0] addr     = '0;
    logic [31:0] wr_data  = '0;
    logic [31:0] vga_stat;
    logic [31:0] rd_data;
    logic        hsync;
    logic        vsync;
    logic [31:0] pixel;
    logic        pixel_valid;

    vga_fb_slave #(
        .word_width(32), .fb_aw(12), .PIX_SHIFT(S),
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_ctrl(vga_ctrl), .addr(addr),
        .wr_data(wr_data), .vga_stat(vga_stat), .rd_data(rd_data),
        .hsync(hsync), .vsync(vsync), .pixel(pixel), .pixel_valid(pixel_valid)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          expLat;
        logic [31:0] expRd;
    } sbEntry_t;

    int          vecCount  = 0;
    int          errCount  = 0;
    sbEntry_t    sbQueue[$];
    logic [31:0] memModel [0:4095];
    logic [31:0] expRdHold = '0;
    int          mH, mV, pH, pV;
    bit          frameChk  = 1'b0;

    // Reference raster position (current and previous cycle).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mH <= 0; mV <= 0; pH <= 0; pV <= 0;
        end else begin
            pH <= mH;
            pV <= mV;
            if (mH == HT - 1) begin
                mH <= 0;
                mV <= (mV == VT - 1) ? 0 : mV + 1;
            end else begin
                mH <= mH + 1;
            end
        end
    end

    function automatic bit isSlot(input int h, input int v);
        return (h < HA) && (v < VA) && ((h % (1 << S)) == 0);
    endfunction

    function automatic bit nextIsSlot(input int h, input int v);
        int nh, nv;
        nh = (h == HT - 1) ? 0 : h + 1;
        nv = (h == HT - 1) ? ((v == VT - 1) ? 0 : v + 1) : v;
        return isSlot(nh, nv);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request; push the expected latency and read data once the
    // ACCESS-cycle raster position is known.
    task automatic applyStimulus(input string tag, input bit wr, input bit rd,
                                 input logic [31:0] a, input logic [31:0] d);
        sbEntry_t e;
        @(negedge clk);
        vga_ctrl = {30'd0, rd, wr};
        addr     = a;
        wr_data  = d;
        @(posedge clk);
        #1;
        e.expLat = isSlot(mH, mV) ? 3 : 2;
        if (wr) begin
            if (a < 32'd4096) memModel[a[11:0]] = d;
        end else begin
            expRdHold = (a < 32'd4096) ? memModel[a[11:0]] : 32'd0;
        end
        e.tag   = tag;
        e.expRd = expRdHold;
        sbQueue.push_back(e);
    endtask

    // Wait (bounded) for ACK, pop the scoreboard and compare.
    task automatic collectResponse(input bit dropReq);
        sbEntry_t e;
        int       n;
        bit       got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (vga_stat[0]) got = 1'b1;
        end
        if (sbQueue.size() == 0) begin
            vecCount++;
            errCount++;
            $error("[TB] FAIL scoreboard_empty: observed=0 entries required=1");
        end else begin
            e = sbQueue.pop_front();
            checkOutput({e.tag, "_ack_seen"}, 32'(got), 32'd1);
            checkOutput({e.tag, "_latency"}, n, e.expLat);
            checkOutput({e.tag, "_rd_data"}, rd_data, e.expRd);
            checkOutput({e.tag, "_stat"}, vga_stat, 32'd1);
            if (dropReq) begin
                @(negedge clk);
                vga_ctrl = '0;
                @(posedge clk);
                #1;
                checkOutput({e.tag, "_ack_drop"}, vga_stat, 32'd0);
            end
        end
    endtask

    // Video output monitor: outputs lag the raster counters by one cycle.
    always @(negedge clk) begin
        bit ev;
        int w;
        if (frameChk) begin
            ev = (pH < HA) && (pV < VA);
            w  = (pV >> S) * (HA >> S) + (pH >> S);
            checkOutput($sformatf("hsync_h%0d_v%0d", pH, pV), 32'(hsync),
                        (pH >= HSS && pH < HSE) ? 0 : 1);
            checkOutput($sformatf("vsync_h%0d_v%0d", pH, pV), 32'(vsync),
                        (pV >= VSS && pV < VSE) ? 0 : 1);
            checkOutput($sformatf("valid_h%0d_v%0d", pH, pV), 32'(pixel_valid), 32'(ev));
            checkOutput($sformatf("pixel_h%0d_v%0d", pH, pV), pixel,
                        ev ? memModel[w] : 32'd0);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int guard;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_stat", vga_stat, 32'd0);
        checkOutput("reset_rd_data", rd_data, 32'd0);
        checkOutput("reset_hsync", 32'(hsync), 32'd1);
        checkOutput("reset_vsync", 32'(vsync), 32'd1);
        checkOutput("reset_pixel", pixel, 32'd0);
        checkOutput("reset_valid", 32'(pixel_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus("wr5", 1'b1, 1'b0, 32'd5, 32'hDEADBEEF); collectResponse(1'b1);
        applyStimulus("rd5", 1'b0, 1'b1, 32'd5, 32'd0);        collectResponse(1'b1);

        applyStimulus("wr0",    1'b1, 1'b0, 32'd0,      32'h0BADF00D); collectResponse(1'b1);
        applyStimulus("wr_oor", 1'b1, 1'b0, 32'h1000,   32'd1);        collectResponse(1'b1);
        applyStimulus("rd_oor", 1'b0, 1'b1, 32'h1000,   32'd0);        collectResponse(1'b1);
        applyStimulus("rd0",    1'b0, 1'b1, 32'd0,      32'd0);        collectResponse(1'b1);

        applyStimulus("both3", 1'b1, 1'b1, 32'd3, 32'h55); collectResponse(1'b1);
        applyStimulus("rd3",   1'b0, 1'b1, 32'd3, 32'd0);  collectResponse(1'b1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("fill%0d", i), 1'b1, 1'b0, 32'(i), 32'(i));
            collectResponse(1'b1);
        end

        guard = 0;
        while (!(mH == HT - 1 && mV == VT - 1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        frameChk = 1'b1;

        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!nextIsSlot(mH, mV) && guard < 50);
        applyStimulus("conflict_rd5", 1'b0, 1'b1, 32'd5, 32'd0);
        collectResponse(1'b1);

        repeat (2 * HT * VT) @(negedge clk);
        frameChk = 1'b0;

        @(negedge clk);
        vga_ctrl = 32'd1;
        addr     = 32'd7;
        wr_data  = 32'h2222;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_access_stat", vga_stat, 32'd0);
        vga_ctrl  = '0;
        expRdHold = '0;
        @(negedge clk);
        checkOutput("rst_access_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        applyStimulus("rd7_after_rst", 1'b0, 1'b1, 32'd7, 32'd0); collectResponse(1'b1);

        applyStimulus("rd3_ack_rst", 1'b0, 1'b1, 32'd3, 32'd0); collectResponse(1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ack_hi_stat", vga_stat, 32'd0);
        checkOutput("rst_ack_hi_rd_data", rd_data, 32'd0);
        vga_ctrl  = '0;
        expRdHold = '0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rd5_final", 1'b0, 1'b1, 32'd5, 32'd0); collectResponse(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
